// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: decoupled IF stage.
// Fetch PC counter -> 1-cycle synchronous instruction ROM -> prefetch FIFO -> decode
// over a valid/ready handshake. A redirect flushes the FIFO and the in-flight read.
// ROM image: word i holds the value i; PCs at or above MEM_DEPTH return a NOP with fault.
// Optional feature macro: IFB_PERF_CNT_EN adds fetchCount/flushCount outputs.
module instruction_fetch_buffer #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter int                  MEM_DEPTH  = 256,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirectPC,
  input  logic                  instrReady,
  output logic                  instrValid,
  output logic [DATA_WIDTH-1:0] fullInstruction,
  output logic [PC_WIDTH-1:0]   instrPC,
  output logic                  instrFault
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [31:0]           fetchCount,
  output logic [31:0]           flushCount
`endif
);

  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] MEM_LIMIT = PC_WIDTH'(MEM_DEPTH);

  // Fetch side: next PC to issue plus the single ROM read in flight.
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [DATA_WIDTH-1:0] inflight_data_q, inflight_data_d;
  logic                  inflight_fault_q, inflight_fault_d;

  // Prefetch FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_d [FIFO_DEPTH];
  logic                  fifo_fault_q [FIFO_DEPTH];
  logic                  fifo_fault_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  out_of_range;
  logic [DATA_WIDTH-1:0] rom_word;

  // ROM contents as a function of the word address.
  function automatic logic [DATA_WIDTH-1:0] rom_read(input logic [ADDR_W-1:0] addr);
    return DATA_WIDTH'(addr);
  endfunction

  // Next-state logic: redirect overrides everything, otherwise issue/push/pop proceed together.
  always_comb begin
    out_of_range     = (fetch_pc_q >= MEM_LIMIT);
    rom_word         = out_of_range ? '0 : rom_read(fetch_pc_q[ADDR_W-1:0]);
    issue            = !redirect && ((count_q + CNT_W'(inflight_q)) < DEPTH_C);
    push             = !redirect && inflight_q;
    pop              = !redirect && (count_q != '0) && instrReady;

    fetch_pc_d       = fetch_pc_q;
    inflight_d       = inflight_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_data_d  = inflight_data_q;
    inflight_fault_d = inflight_fault_q;
    fifo_data_d      = fifo_data_q;
    fifo_pc_d        = fifo_pc_q;
    fifo_fault_d     = fifo_fault_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;

    if (redirect) begin
      fetch_pc_d = redirectPC;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d       = fetch_pc_q + PC_STEP;
        inflight_pc_d    = fetch_pc_q;
        inflight_data_d  = rom_word;
        inflight_fault_d = out_of_range;
      end
      if (push) begin
        fifo_data_d[wr_ptr_q]  = inflight_data_q;
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        fifo_fault_d[wr_ptr_q] = inflight_fault_q;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers, cleared asynchronously so a reset mid-fetch drops everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_data_q  <= '0;
      inflight_fault_q <= 1'b0;
      fifo_data_q      <= '{default: '0};
      fifo_pc_q        <= '{default: '0};
      fifo_fault_q     <= '{default: 1'b0};
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_data_q  <= inflight_data_d;
      inflight_fault_q <= inflight_fault_d;
      fifo_data_q      <= fifo_data_d;
      fifo_pc_q        <= fifo_pc_d;
      fifo_fault_q     <= fifo_fault_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
    end
  end

  // Head of the FIFO drives decode directly; all fields read zero while empty.
  always_comb begin
    instrValid      = (count_q != '0);
    fullInstruction = '0;
    instrPC         = '0;
    instrFault      = 1'b0;
    if (instrValid) begin
      fullInstruction = fifo_data_q[rd_ptr_q];
      instrPC         = fifo_pc_q[rd_ptr_q];
      instrFault      = fifo_fault_q[rd_ptr_q];
    end
  end

`ifdef IFB_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Counters: accepted instructions and cycles spent under redirect.
  always_comb begin
    fetch_count_d = fetch_count_q + {31'b0, pop};
    flush_count_d = flush_count_q + {31'b0, redirect};
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetchCount = fetch_count_q;
  assign flushCount = flush_count_q;
`endif

endmodule
